// File: rtl/csa_pkg.sv
// Shared types and defaults for the sequential carry-save resolver.
package csa_pkg;

    localparam int N_DEFAULT     = 1024;
    localparam int CHUNK_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width that stays legal when there is only one chunk.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/csa_resolve_seq_chunk_add.sv
// Combinational W-bit adder with carry-in and carry-out; one chunk of the resolver.
module chunk_add #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/csa_resolve_seq.sv
// Resolves a carry-save pair into binary, CHUNK bits per clock, with a
// valid/ready operand input and a valid/ready result output.
module csa_resolve_seq
    import csa_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] sum_in,
    input  logic [N-1:0] carry_in,
    input  logic         cin_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N:0]   result_out
);

    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = N / CHUNK_SAFE;
    localparam int IDX_W      = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    if ((CHUNK < 1) || ((N % CHUNK_SAFE) != 0)) begin : g_bad_params
        $error("csa_resolve_seq: N must be a multiple of CHUNK and CHUNK >= 1");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     sum_q, sum_d;
    logic [N-1:0]     car_q, car_d;
    logic [N:0]       result_q, result_d;
    logic             m_valid_q, m_valid_d;

    logic             accept;
    int unsigned      base;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_co;

    // DONE passes m_ready straight through so a new operand can enter as the result leaves.
    assign s_ready    = (state_q == IDLE) || ((state_q == DONE) && m_ready);
    assign accept     = s_valid && s_ready;
    assign m_valid    = m_valid_q;
    assign result_out = result_q;
    assign base       = int'(idx_q) * CHUNK;

    chunk_add #(.W(CHUNK)) u_chunk_add (
        .a  (sum_q[base +: CHUNK]),
        .b  (car_q[base +: CHUNK]),
        .ci (carry_q),
        .s  (chunk_sum),
        .co (chunk_co)
    );

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        car_d     = car_q;
        result_d  = result_q;
        m_valid_d = m_valid_q;

        case (state_q)
            IDLE: ;
            RUN: begin
                result_d[base +: CHUNK] = chunk_sum;
                carry_d                 = chunk_co;
                if (idx_q == LAST) begin
                    result_d[N] = chunk_co;
                    state_d     = DONE;
                    m_valid_d   = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept only occurs in IDLE or DONE with m_ready, so it overrides the above.
        if (accept) begin
            sum_d     = sum_in;
            car_d     = carry_in;
            carry_d   = cin_in;
            idx_d     = '0;
            state_d   = RUN;
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            // NOTE: operand and result registers are reset too so result_out is never X.
            sum_q     <= '0;
            car_q     <= '0;
            result_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
            car_q     <= car_d;
            result_q  <= result_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Scoreboard bench: a small instance (N=8, CHUNK=4) for directed cases and a
// full-size instance (N=1024, CHUNK=64) for random operands with backpressure.
module tb_csa_resolve_seq;

    localparam int SN  = 8;
    localparam int SC  = 4;
    localparam int SNC = SN / SC;
    localparam int LN  = 1024;
    localparam int LC  = 64;
    localparam int LNC = LN / LC;
    localparam int N_RAND_A = 300;
    localparam int N_RAND_B = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    logic          s_valid_a = 1'b0, s_ready_a, cin_a = 1'b0, m_valid_a, m_ready_a = 1'b0;
    logic [SN-1:0] sum_a = '0, car_a = '0;
    logic [SN:0]   res_a;

    logic          s_valid_b = 1'b0, s_ready_b, cin_b = 1'b0, m_valid_b, m_ready_b = 1'b0;
    logic [LN-1:0] sum_b = '0, car_b = '0;
    logic [LN:0]   res_b;

    csa_resolve_seq #(.N(SN), .CHUNK(SC)) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .sum_in(sum_a), .carry_in(car_a), .cin_in(cin_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .result_out(res_a)
    );

    csa_resolve_seq #(.N(LN), .CHUNK(LC)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .sum_in(sum_b), .carry_in(car_b), .cin_in(cin_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .result_out(res_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [SN:0] exp_a[$];
    int          acc_a[$];
    logic [LN:0] exp_b[$];
    int          acc_b[$];

    bit rnd_a = 1'b0;
    bit rnd_b = 1'b0;

    task automatic check(input string name, input logic [LN:0] act, input logic [LN:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (low 128 bits) at cycle %0d",
                     name, act[127:0], exp[127:0], cyc);
        end
    endtask

    // Random backpressure, driven just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_a) m_ready_a = 1'($urandom_range(0, 1));
        if (rnd_b) m_ready_b = ($urandom_range(0, 3) != 0);
    end

    // Monitor for the small instance.
    initial begin : mon_a
        logic pv, pr;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (pv && !pr) check("a_valid_held", m_valid_a, 1);
                if (m_valid_a) begin
                    if (!pv) begin
                        if (acc_a.size() == 0) check("a_spurious_valid", m_valid_a, 0);
                        else check("a_latency", cyc - acc_a.pop_front(), SNC);
                    end
                    if (exp_a.size() == 0) begin
                        check("a_unexpected_result", m_valid_a, 0);
                    end else begin
                        check("a_result", res_a, exp_a[0]);
                        if (m_ready_a) void'(exp_a.pop_front());
                    end
                end
                pv = m_valid_a;
                pr = m_ready_a;
            end
        end
    end

    // Monitor for the full-size instance.
    initial begin : mon_b
        logic pv, pr;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (pv && !pr) check("b_valid_held", m_valid_b, 1);
                if (m_valid_b) begin
                    if (!pv) begin
                        if (acc_b.size() == 0) check("b_spurious_valid", m_valid_b, 0);
                        else check("b_latency", cyc - acc_b.pop_front(), LNC);
                    end
                    if (exp_b.size() == 0) begin
                        check("b_unexpected_result", m_valid_b, 0);
                    end else begin
                        check("b_result", res_b, exp_b[0]);
                        if (m_ready_b) void'(exp_b.pop_front());
                    end
                end
                pv = m_valid_b;
                pr = m_ready_b;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_a(input logic [SN-1:0] s, input logic [SN-1:0] c, input logic ci,
                          output int waited);
        logic [SN:0] e;
        waited = 0;
        sum_a = s; car_a = c; cin_a = ci; s_valid_a = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready_a || waited >= 100) break;
            waited++;
        end
        if (s_ready_a) begin
            e = s + c + ci;
            exp_a.push_back(e);
            acc_a.push_back(cyc + 1);
        end else begin
            check("a_accept_timeout", s_ready_a, 1);
        end
        @(posedge clk);
        #1;
        s_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [LN-1:0] s, input logic [LN-1:0] c, input logic ci);
        int waited;
        logic [LN:0] e;
        waited = 0;
        sum_b = s; car_b = c; cin_b = ci; s_valid_b = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready_b || waited >= 200) break;
            waited++;
        end
        if (s_ready_b) begin
            e = s + c + ci;
            exp_b.push_back(e);
            acc_b.push_back(cyc + 1);
        end else begin
            check("b_accept_timeout", s_ready_b, 1);
        end
        @(posedge clk);
        #1;
        s_valid_b = 1'b0;
    endtask

    task automatic drain_a(input int limit);
        int n = 0;
        while (exp_a.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (exp_a.size() != 0) check("a_drain_timeout", exp_a.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_b(input int limit);
        int n = 0;
        while (exp_b.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (exp_b.size() != 0) check("b_drain_timeout", exp_b.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int n;
        logic [LN-1:0] bs, bc;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("a_rst_s_ready", s_ready_a, 1);
        check("a_rst_m_valid", m_valid_a, 0);
        check("a_rst_result", res_a, 0);
        check("b_rst_s_ready", s_ready_b, 1);
        check("b_rst_m_valid", m_valid_b, 0);
        check("b_rst_result", res_b, 0);
        @(posedge clk);
        #1;

        // Carry ripples through every chunk, then the overflow maximum.
        m_ready_a = 1'b1;
        send_a(8'hFF, 8'h01, 1'b0, w);
        drain_a(20);
        send_a(8'hFF, 8'hFF, 1'b1, w);
        drain_a(20);

        // Hold the result under backpressure, then release with a same-cycle accept.
        m_ready_a = 1'b0;
        send_a(8'h0F, 8'h01, 1'b0, w);
        n = 0;
        while (!m_valid_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("a_hold_s_ready", s_ready_a, 0);
            check("a_hold_m_valid", m_valid_a, 1);
            check("a_hold_result", res_a, 9'h010);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_ready_a = 1'b1;
        send_a(8'h12, 8'h34, 1'b1, w);
        check("a_same_cycle_accept", w, 0);
        drain_a(20);

        // Reset after the first RUN cycle discards the operation.
        send_a(8'h33, 8'h44, 1'b0, w);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_a.delete();
        acc_a.delete();
        @(negedge clk);
        check("a_midrun_rst_m_valid", m_valid_a, 0);
        check("a_midrun_rst_result", res_a, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("a_post_rst_m_valid", m_valid_a, 0);
            check("a_post_rst_s_ready", s_ready_a, 1);
            check("a_post_rst_result", res_a, 0);
        end
        @(posedge clk);
        #1;
        send_a(8'h80, 8'h80, 1'b1, w);
        drain_a(20);

        // Input activity during RUN must not be accepted nor disturb the result.
        send_a(8'h11, 8'h22, 1'b0, w);
        sum_a = SN'($urandom); car_a = SN'($urandom); cin_a = 1'b1; s_valid_a = 1'b1;
        @(negedge clk);
        check("a_busy_s_ready", s_ready_a, 0);
        @(posedge clk);
        #1;
        sum_a = SN'($urandom); car_a = SN'($urandom); s_valid_a = 1'b0;
        drain_a(20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_no_extra_valid", m_valid_a, 0);
        end
        @(posedge clk);
        #1;

        // Random operands on the small instance with backpressure.
        rnd_a = 1'b1;
        for (int i = 0; i < N_RAND_A; i++)
            send_a(SN'($urandom), SN'($urandom), 1'($urandom_range(0, 1)), w);
        drain_a(400);
        rnd_a = 1'b0;
        m_ready_a = 1'b1;

        // Random operands on the full-size instance, with periodic all-ones corners.
        rnd_b = 1'b1;
        for (int i = 0; i < N_RAND_B; i++) begin
            if (i % 97 == 0) begin
                bs = '1;
                bc = '1;
                send_b(bs, bc, 1'b1);
            end else begin
                for (int j = 0; j < LN / 32; j++) begin
                    bs[j*32 +: 32] = $urandom;
                    bc[j*32 +: 32] = $urandom;
                end
                send_b(bs, bc, 1'($urandom_range(0, 1)));
            end
        end
        drain_b(400);
        rnd_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
